// File: rtl/note_scheduler_pkg.sv
// Shared types and constants for the note scheduler.
// Package sass_pkg:
//   note_t / octave_t  - widths of the divider's note and octave inputs
//   sched_state_t      - scheduler states
//   NOTE_MAX / OCT_MAX - highest note code and highest octave
//   oct_step()         - saturating octave up/down step
package sass_pkg;

    typedef logic [3:0] note_t;
    typedef logic [2:0] octave_t;

    typedef enum logic [1:0] {IDLE, PLAY, WAIT_WRAP, RELEASE} sched_state_t;

    localparam note_t   NOTE_MAX = 4'd11;
    localparam octave_t OCT_MAX  = 3'd7;

    // Simultaneous up and down presses cancel each other.
    function automatic octave_t oct_step(input octave_t cur, input logic up, input logic dn);
        octave_t r;
        r = cur;
        if (up && !dn && cur != OCT_MAX) begin
            r = cur + 3'd1;
        end else if (dn && !up && cur != 3'd0) begin
            r = cur - 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Button-side and divider-side signals of the note scheduler.
//   keys, oct_up, oct_dn, osc_wrap, sustain : into the scheduler
//   note, octave, gate, load, busy          : out of the scheduler
// Modports: master = scheduler, slave = buttons/oscillator environment.
interface note_scheduler_if #(parameter int NKEYS = 12);
    import sass_pkg::*;

    logic [NKEYS-1:0] keys;
    logic             oct_up;
    logic             oct_dn;
    logic             osc_wrap;
    logic             sustain;
    note_t            note;
    octave_t          octave;
    logic             gate;
    logic             load;
    logic             busy;

    modport master (
        input  keys, oct_up, oct_dn, osc_wrap, sustain,
        output note, octave, gate, load, busy
    );

    modport slave (
        output keys, oct_up, oct_dn, osc_wrap, sustain,
        input  note, octave, gate, load, busy
    );

endinterface

// File: rtl/note_scheduler_edge_det.sv
// Rising-edge detector with registered history.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   d_i    - level inputs
//   rise_o - 1 where d_i went 0->1 since the previous cycle
// During reset the history loads the live inputs, so a level that is
// already high when reset releases never reports a rise.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] hist_q;

    always_ff @(posedge clk_i) begin
        hist_q <= d_i;
    end

    assign rise_o = d_i & ~hist_q & {W{~rst_i}};

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: picks which held key owns the single oscillator and
// defers every retune and note-off to an oscillator period boundary.
//   hwclk  - system clock
//   reset  - synchronous active-high reset
//   bus    - note_scheduler_if.master (keys, octave buttons, osc_wrap,
//            sustain in; note, octave, gate, load, busy out)
// Optional: define NOTE_SCHED_SUSTAIN_EN to let the sustain pedal hold
// the last note when all keys are released.
module note_scheduler
    import sass_pkg::*;
#(
    parameter int NKEYS        = 12,
    parameter int OCT_RESET    = 4,
    parameter int WRAP_TIMEOUT = 262143
) (
    input logic               hwclk,
    input logic               reset,
    note_scheduler_if.master  bus
);

    localparam int                CNT_W    = $clog2(WRAP_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WRAP_TIMEOUT - 1);

    logic [NKEYS-1:0] key_rise;
    logic [1:0]       oct_rise;

    sched_state_t     state_q, state_d;
    note_t            note_q, note_d;
    octave_t          oct_q, oct_d;
    logic             gate_q, gate_d;
    logic             load_q, load_d;
    note_t            cand_q, cand_d;
    octave_t          pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any_press;
    logic             all_off;
    logic             rel_req;
    logic             wrap_now;
    logic [CNT_W-1:0] cnt_inc;

    edge_det #(.W(NKEYS)) u_key_ed (
        .clk_i  (hwclk),
        .rst_i  (reset),
        .d_i    (bus.keys),
        .rise_o (key_rise)
    );

    edge_det #(.W(2)) u_oct_ed (
        .clk_i  (hwclk),
        .rst_i  (reset),
        .d_i    ({bus.oct_dn, bus.oct_up}),
        .rise_o (oct_rise)
    );

    function automatic note_t lowest(input logic [NKEYS-1:0] v);
        note_t r;
        r = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i] && note_t'(i) <= NOTE_MAX) begin
                r = note_t'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        any_press = |key_rise;
        all_off   = ~|bus.keys;
`ifdef NOTE_SCHED_SUSTAIN_EN
        // Pedal down holds the note; lifting it with no key held releases.
        rel_req   = all_off && !bus.sustain;
`else
        rel_req   = all_off;
`endif
        wrap_now  = bus.osc_wrap || (cnt_q == CNT_LAST);
        cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;

        // Newest press wins; losing the active key falls back to the
        // lowest-index key still held.
        cand_d = cand_q;
        if (any_press) begin
            cand_d = lowest(key_rise);
        end else if (!all_off && !bus.keys[cand_q]) begin
            cand_d = lowest(bus.keys);
        end
        pend_d = oct_step(pend_q, oct_rise[0], oct_rise[1]);

        state_d = state_q;
        note_d  = note_q;
        oct_d   = oct_q;
        gate_d  = gate_q;
        load_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (any_press) begin
                    state_d = PLAY;
                    note_d  = cand_d;
                    oct_d   = pend_d;
                    load_d  = 1'b1;
                    gate_d  = 1'b1;
                end
            end
            PLAY: begin
                if (rel_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cand_d != note_q || pend_d != oct_q) begin
                    state_d = WAIT_WRAP;
                    cnt_d   = '0;
                end
            end
            WAIT_WRAP: begin
                if (rel_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (wrap_now) begin
                    // Apply what was registered at the wrap; a press in this
                    // same cycle re-enters WAIT_WRAP from PLAY.
                    state_d = PLAY;
                    note_d  = cand_q;
                    oct_d   = pend_q;
                    load_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            RELEASE: begin
                if (any_press) begin
                    state_d = WAIT_WRAP;
                    cnt_d   = '0;
                end else if (wrap_now) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q <= IDLE;
            note_q  <= '0;
            oct_q   <= octave_t'(OCT_RESET);
            gate_q  <= 1'b0;
            load_q  <= 1'b0;
            cand_q  <= '0;
            pend_q  <= octave_t'(OCT_RESET);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            gate_q  <= gate_d;
            load_q  <= load_d;
            cand_q  <= cand_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.note   = note_q;
    assign bus.octave = oct_q;
    assign bus.gate   = gate_q;
    assign bus.load   = load_q;
    assign bus.busy   = (state_q == WAIT_WRAP) || (state_q == RELEASE);

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences the single note/octave frequency-divider datapath from the 12 note push-buttons plus octave up/down buttons.
- Decides which held key owns the oscillator, using newest-press priority with fallback to the lowest-index held key.
- Defers every retune and every note-off to an oscillator period boundary (osc_wrap), so the divider never restarts mid-cycle.
- Sits between the button inputs (pb) and the divider/oscillator in top.

Parameters:
- NKEYS, 12, number of note keys; a key index is the note code 0..11.
- OCT_RESET, 4, octave value loaded at reset.
- WRAP_TIMEOUT, 262143, maximum number of cycles to wait for osc_wrap before forcing the pending action.

Ports:
- hwclk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- keys  input  NKEYS  note key levels, already synchronized; 1 = held
- oct_up  input  1  octave-up button level
- oct_dn  input  1  octave-down button level
- osc_wrap  input  1  one-cycle pulse from the oscillator at each period boundary
- sustain  input  1  sustain pedal level (see Optional Feature)
- note  output  4  note code applied to the divider
- octave  output  3  octave applied to the divider
- gate  output  1  oscillator enable / audible
- load  output  1  one-cycle strobe: the divider latches note/octave
- busy  output  1  high in WAIT_WRAP and RELEASE

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - note=0, octave=OCT_RESET, gate=0, load=0, busy=0.
  - State=IDLE, timeout counter=0, candidate=0, pending octave=OCT_RESET.
  - Edge-detect history registers take the current input values, so keys held through reset do not generate presses.
- Edge detection: a press is a 0->1 transition on keys[i], oct_up or oct_dn, detected with registered history.
- Same-cycle presses: when several keys are pressed in one cycle, the lowest index wins.
- Candidate register: updated on any press to that key index.
- Active-key release: if other keys are still held, the candidate becomes the lowest-index held key.
- Octave update:
  - oct_up increments the pending octave, saturating at 7.
  - oct_dn decrements it, saturating at 0.
  - If both are pressed in the same cycle, the pending octave is unchanged.
- IDLE:
  - A key press moves to PLAY in the next cycle.
  - In that cycle note=key and octave=pending, with load=1 and gate=1 (latency: 1 cycle from the press edge).
  - An octave press in IDLE updates only the pending octave; no load is issued.
- PLAY: any candidate or pending-octave change versus the applied note/octave moves to WAIT_WRAP and clears the timeout counter.
- Release to silence: when all keys are released in PLAY or WAIT_WRAP, the state moves to RELEASE.
- WAIT_WRAP:
  - Counts cycles.
  - On osc_wrap, or when the count reaches WRAP_TIMEOUT-1, the next cycle applies the candidate and pending octave, pulses load, and returns to PLAY.
  - The applied values are those registered at the wrap cycle; a press in the same cycle as the wrap is handled by a new WAIT_WRAP afterwards.
- RELEASE:
  - gate stays 1 until osc_wrap or timeout; then gate=0 and the state returns to IDLE. No load is issued.
  - A key press during RELEASE cancels the release: the candidate updates and the state moves to WAIT_WRAP with gate kept at 1.
- load: never asserted on two consecutive cycles.
- Timeout counter: width $clog2(WRAP_TIMEOUT); it does not wrap past WRAP_TIMEOUT-1.

Optional Feature:
- Macro: NOTE_SCHED_SUSTAIN_EN.
- With the macro defined and sustain=1:
  - An all-keys-released condition does not enter RELEASE.
  - The last note keeps sounding and the state stays in PLAY.
  - A falling edge of sustain while no key is held enters RELEASE.
- Without the macro, the sustain port is present but ignored, and no logic is generated for it.

Decomposition:
- Package sass_pkg:
  - typedef note_t (logic [3:0]) and octave_t (logic [2:0]).
  - Enum sched_state_t {IDLE, PLAY, WAIT_WRAP, RELEASE}.
  - Constants NOTE_MAX=11 and OCT_MAX=7.
- Sub-module: edge_det (parameterized width, registered rising-edge detect, synchronous reset). Instantiated once for keys and once for the octave buttons.

Test Plan:
- Reset then press keys[5] -> one cycle later note=5, octave=4, load=1 for exactly 1 cycle, gate=1, busy=0.
- While keys[5] is held, press keys[9]; osc_wrap 20 cycles later -> busy=1 for those cycles, then note=9 with a single load pulse the cycle after the wrap.
- Hold keys[2] and keys[7] (7 active), release 7 -> WAIT_WRAP; after osc_wrap, note=2 and load pulses.
- Release all keys with osc_wrap withheld -> gate=1 for WAIT_WRAP_TIMEOUT cycles, then gate=0, IDLE, no load.
- Octave:
  - oct_up pressed 5 times from 4 -> octave saturates at 7.
  - While in PLAY, the retune applies only at osc_wrap.
  - oct_up and oct_dn in the same cycle -> no change.
- Assert reset while in WAIT_WRAP with keys held -> next cycle all outputs are at reset values; no spurious press occurs after reset deasserts.
